// File: rtl/shop_pkg.sv
// Shared definitions for the shop command front end and the shop core:
// ASCII constants, assembler state encoding and the shared width parameters.
package shop_pkg;

    localparam int A_NUM_ASCII_CHARS = 7;
    localparam int U_NUM_BITS        = 4;

    localparam logic [7:0] CHAR_CR       = 8'h0D;
    localparam logic [7:0] CHAR_LF       = 8'h0A;
    localparam logic [7:0] CHAR_BS       = 8'h08;
    localparam logic [7:0] CHAR_AT       = 8'h40;
    localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DISCARD = 2'd1,
        S_ISSUE   = 2'd2,
        S_GAP     = 2'd3
    } asm_state_t;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module hex_ascii_decode (
    input  logic [7:0] i_char,
    output logic       o_is_hex,
    output logic [3:0] o_val
);

    // Classify the character and produce its nibble value.
    always_comb begin
        o_is_hex = 1'b0;
        o_val    = 4'd0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_is_hex = 1'b1;
            o_val    = 4'(i_char - 8'h30);
        end else if (i_char >= 8'h41 && i_char <= 8'h46) begin
            o_is_hex = 1'b1;
            o_val    = 4'(i_char - 8'h37);
        end else if (i_char >= 8'h61 && i_char <= 8'h66) begin
            o_is_hex = 1'b1;
            o_val    = 4'(i_char - 8'h57);
        end
    end

endmodule

// File: rtl/shop_cmd_assembler.sv
// Byte-serial ASCII line assembler feeding the shop core.
// Collects a line, strobes the right-aligned word on o_a (o_rdy), handles
// "@<hex>" user-select lines on o_u, flags overlong/bad lines on o_err and
// holds off input for GAP_CYCLES after every issued line.
// Optional feature macro: SHOP_CMD_ASM_BACKSPACE_EN enables BS line editing;
// when undefined BS is treated as an ignored non-printable byte.
module shop_cmd_assembler
    import shop_pkg::*;
#(
    parameter int A_NUM_ASCII_CHARS = shop_pkg::A_NUM_ASCII_CHARS,
    parameter int A_NUM_BITS        = A_NUM_ASCII_CHARS * 8,
    parameter int U_NUM_BITS        = shop_pkg::U_NUM_BITS,
    parameter int GAP_CYCLES        = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_char_vld,
    input  logic [7:0]            i_char,
    output logic                  o_char_rdy,
    output logic [A_NUM_BITS-1:0] o_a,
    output logic [U_NUM_BITS-1:0] o_u,
    output logic                  o_rdy,
    output logic                  o_err
);

    localparam int CNT_W = $clog2(A_NUM_ASCII_CHARS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    asm_state_t            state_q, state_d;
    logic [A_NUM_BITS-1:0] line_q, line_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [A_NUM_BITS-1:0] a_q, a_d;
    logic [U_NUM_BITS-1:0] u_q, u_d;
    logic                  rdy_q, rdy_d;
    logic                  err_q, err_d;

    logic [7:0] first_char;
    logic       last_is_hex;
    logic [3:0] last_hex_val;
    logic       is_printable;

    hex_ascii_decode u_hex (
        .i_char   (line_q[7:0]),
        .o_is_hex (last_is_hex),
        .o_val    (last_hex_val)
    );

    // Pick out the first (oldest) character of the current line.
    always_comb begin
        first_char = 8'h00;
        for (int i = 0; i < A_NUM_ASCII_CHARS; i++) begin
            if (count_q == CNT_W'(i + 1)) first_char = line_q[8*i +: 8];
        end
    end

    assign is_printable = (i_char >= CHAR_PRINT_LO) && (i_char <= CHAR_PRINT_HI);

    // Characters are only taken while collecting or discarding, never in reset.
    assign o_char_rdy = !i_reset && ((state_q == S_COLLECT) || (state_q == S_DISCARD));

    // Next-state, line editing and output load decisions.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        count_d = count_q;
        gap_d   = gap_q;
        a_d     = a_q;
        u_d     = u_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (i_char_vld) begin
                    if (i_char == CHAR_CR) begin
                        if (count_q == '0) begin
                            state_d = S_COLLECT;
                        end else if (first_char == CHAR_AT) begin
                            if (count_q == CNT_W'(2) && last_is_hex) u_d = U_NUM_BITS'(last_hex_val);
                            else                                     err_d = 1'b1;
                            state_d = S_ISSUE;
                        end else begin
                            a_d     = line_q;
                            rdy_d   = 1'b1;
                            state_d = S_ISSUE;
                        end
                    end else if (is_printable) begin
                        if (count_q < CNT_W'(A_NUM_ASCII_CHARS)) begin
                            line_d  = {line_q[A_NUM_BITS-9:0], i_char};
                            count_d = count_q + 1'b1;
                        end else begin
                            state_d = S_DISCARD;
                        end
                    end
`ifdef SHOP_CMD_ASM_BACKSPACE_EN
                    else if (i_char == CHAR_BS && count_q != '0) begin
                        line_d  = line_q >> 8;
                        count_d = count_q - 1'b1;
                    end
`endif
                end
            end
            S_DISCARD: begin
                if (i_char_vld && i_char == CHAR_CR) begin
                    err_d   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                line_d  = '0;
                count_d = '0;
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = S_COLLECT;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    // State and output registers; reset drops any partial line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_COLLECT;
            line_q  <= '0;
            count_q <= '0;
            gap_q   <= '0;
            a_q     <= '0;
            u_q     <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            count_q <= count_d;
            gap_q   <= gap_d;
            a_q     <= a_d;
            u_q     <= u_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign o_a   = a_q;
    assign o_u   = u_q;
    assign o_rdy = rdy_q;
    assign o_err = err_q;

endmodule

// File: doc/shop_cmd_assembler.md
# shop_cmd_assembler

Upstream front end for the shop database FSM. Converts a byte-serial ASCII character stream (terminal/UART side) into the word-parallel command/argument format the shop core consumes: a right-aligned ASCII word on `o_a` with a one-cycle `o_rdy` strobe, plus a registered user index on `o_u`. It owns line editing, overflow detection and the inter-command gap the shop core needs between strobes.

## Interface
- `A_NUM_ASCII_CHARS`, 7: maximum characters per line; must fit the longest command key.
- `A_NUM_BITS`, `A_NUM_ASCII_CHARS*8`: width of `o_a`.
- `U_NUM_BITS`, 4: width of `o_u`; values up to 15.
- `GAP_CYCLES`, 2: idle cycles after each issue before new characters are accepted; minimum 1.
- `i_clk` in 1: the only clock; all logic is on its rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_char_vld` in 1: source presents a character.
- `i_char` in 8: ASCII character.
- `o_char_rdy` out 1: block accepts a character; a transfer occurs when `i_char_vld && o_char_rdy` at a rising edge.
- `o_a` out `A_NUM_BITS`: assembled word, right-aligned. Last character is in `[7:0]`; unused MSBs are zero.
- `o_u` out `U_NUM_BITS`: current user index.
- `o_rdy` out 1: one-cycle strobe; `o_a` holds a new word. Connects to the shop `i_rdy`.
- `o_err` out 1: one-cycle strobe; the line was rejected.

## Operation
- States: COLLECT, DISCARD, ISSUE, GAP. Reset state is COLLECT.
- Character classes:
  - CR (0x0D) is the line terminator.
  - BS (0x08) is backspace.
  - Printable characters are 0x20–0x7E.
  - All other bytes, including LF, are accepted and ignored, so CRLF works.
- COLLECT, printable character:
  - If count < `A_NUM_ASCII_CHARS`: shift register `line <= {line[A_NUM_BITS-9:0], char}` and increment count.
  - Otherwise: go to DISCARD with the error flag set.
- COLLECT, BS:
  - If count > 0: `line <= line >> 8` and decrement count.
  - If count is 0: no effect.
- COLLECT, CR:
  - count == 0: empty line, ignored; stay in COLLECT.
  - Line is exactly `@` followed by one hex digit (0-9, A-F, a-f): load `o_u` with that value; no strobe; go to ISSUE.
  - `@` line in any other form: error.
  - Any other line: load `o_a <= line`; go to ISSUE with the strobe pending.
- DISCARD: accepts and drops every character. On CR, go to ISSUE with the error flag set.
- ISSUE (one cycle): drive exactly one of `o_rdy` or `o_err` (or neither, for an `@` line). Clear line, count and flag. Go to GAP.
- GAP: count `GAP_CYCLES` cycles, then return to COLLECT.
- `o_char_rdy` = 1 only in COLLECT/DISCARD, and 0 while `i_reset` is high.
- `o_a` and `o_u` change only when loaded and hold otherwise. `o_err` never alters `o_a` or `o_u`.
- Reset values: `o_a`=0, `o_u`=0, `o_rdy`=0, `o_err`=0, line=0, count=0, state COLLECT.
- Reset mid-line discards the partial line. The first character after reset deassertion starts a fresh line.

## Timing
- CR accepted at edge N → `o_a`/`o_u` updated and `o_rdy`/`o_err` high during cycle N+1 only.
- `o_char_rdy` is low from cycle N+1 through N+1+`GAP_CYCLES`, and high again at cycle N+2+`GAP_CYCLES`.
- One character per cycle maximum. A back-to-back stream incurs no stall in COLLECT/DISCARD.
- All outputs are registered except `o_char_rdy`, which is decoded from state and reset.

## Configuration
- `SHOP_CMD_ASM_BACKSPACE_EN` defined: BS editing as described above.
- `SHOP_CMD_ASM_BACKSPACE_EN` undefined: BS is treated as an ignored non-printable byte, and the count never decrements.

## Structure
- Shared package `shop_pkg` holds:
  - ASCII constants: CR, LF, BS, `@`, printable bounds.
  - The state enum.
  - The width parameters shared with the shop core: `A_NUM_ASCII_CHARS`, `U_NUM_BITS`.
- One sub-module: `hex_ascii_decode`, a combinational block taking an 8-bit char and producing `is_hex` plus a 4-bit value.

## Test plan
- "Login",CR → `o_a`=56'h0000_4C6F_6769_6E; `o_rdy` high exactly one cycle at N+1; `o_char_rdy` low for 1+`GAP_CYCLES` cycles.
- "@3",CR → `o_u`=3; no `o_rdy`; no `o_err`; `o_a` unchanged. "@G",CR → `o_err` pulse; `o_u` stays 3.
- "AddItemX",CR (8 chars) → `o_err` one cycle; `o_a` unchanged; the next line "Buy",CR → `o_a`=56'h0000_0000_4275_79.
- With the macro defined: "Az",BS,"dm",CR → `o_a`=56'h0000_0000_4164_6D. Without it: BS ignored, and the result is "Azdm" = 56'h0000_0041_7A64_6D.
- Lone CR, and LF-only lines → no strobe, state returns to COLLECT with no gap.
- "Log", then `i_reset` pulse, then "in",CR → `o_a`=56'h0000_0000_0069_6E; all outputs are 0 during reset.
